// File: rtl/specular_term.sv
// Specular term: clamp(N.H) computed on one serial FP multiplier and one serial FP adder,
// then raised to the shininess power by the external power unit.

module specular_fpu #(
    parameter bit IS_ADD = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_stb,
    input  logic        b_stb,
    output logic        a_ack,
    output logic        b_ack,
    output logic [31:0] z,
    output logic        z_stb,
    input  logic        z_ack
);
    localparam logic [1:0] F_IDLE = 2'd0, F_CALC = 2'd1, F_DONE = 2'd2;

    logic [1:0]  phase_q, phase_d;
    logic [31:0] a_op_q, a_op_d, b_op_q, b_op_d, z_q, z_d;
    logic        ack_q, ack_d, z_stb_q, z_stb_d;

    // Round-to-nearest-even on a normalised 1.m mantissa; subnormal results flush to signed zero.
    function automatic logic [31:0] fp_pack(input logic s, input logic signed [10:0] e,
                                            input logic [23:0] m, input logic g, input logic st);
        logic [24:0]        r;
        logic signed [10:0] ef;
        r  = {1'b0, m} + ((g && (st || m[0])) ? 25'd1 : 25'd0);
        ef = e;
        if (r[24]) begin
            r  = r >> 1;
            ef = ef + 11'sd1;
        end
        if (ef >= 11'sd255)    fp_pack = {s, 8'hff, 23'd0};
        else if (ef <= 11'sd0) fp_pack = {s, 31'd0};
        else                   fp_pack = {s, ef[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic               s, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        logic [47:0]        p;
        logic signed [10:0] e;
        s      = x[31] ^ y[31];
        x_zero = (x[30:23] == 8'd0);
        y_zero = (y[30:23] == 8'd0);
        x_inf  = (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
        y_inf  = (y[30:23] == 8'hff) && (y[22:0] == 23'd0);
        x_nan  = (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
        y_nan  = (y[30:23] == 8'hff) && (y[22:0] != 23'd0);
        p      = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e      = $signed({3'b000, x[30:23]}) + $signed({3'b000, y[30:23]}) - 11'sd127;
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) fp_mul = 32'h7fc00000;
        else if (x_inf || y_inf)   fp_mul = {s, 8'hff, 23'd0};
        else if (x_zero || y_zero) fp_mul = {s, 31'd0};
        else if (p[47])            fp_mul = fp_pack(s, e + 11'sd1, p[47:24], p[23], |p[22:0]);
        else                       fp_mul = fp_pack(s, e, p[46:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]        l, sm;
        logic [27:0]        ml, ms, sum;
        logic [7:0]         sh;
        logic               st, x_inf, y_inf, x_nan, y_nan;
        logic signed [10:0] e;
        x_inf = (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
        y_inf = (y[30:23] == 8'hff) && (y[22:0] == 23'd0);
        x_nan = (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
        y_nan = (y[30:23] == 8'hff) && (y[22:0] != 23'd0);
        l     = (x[30:0] >= y[30:0]) ? x : y;
        sm    = (x[30:0] >= y[30:0]) ? y : x;
        sh    = l[30:23] - sm[30:23];
        // Mantissas carry three guard/round/sticky bits below the LSB; sticky folds into bit 0.
        ml    = {2'b01, l[22:0], 3'b000};
        ms    = {2'b01, sm[22:0], 3'b000};
        st    = ((ms >> sh) << sh) != ms;
        ms    = (ms >> sh) | {27'd0, st};
        sum   = (l[31] == sm[31]) ? ml + ms : ml - ms;
        e     = $signed({3'b000, l[30:23]});
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 11'sd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!sum[26]) begin
                    sum = sum << 1;
                    e   = e - 11'sd1;
                end
            end
        end
        if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) fp_add = 32'h7fc00000;
        else if (x_inf)                                    fp_add = x;
        else if (y_inf)                                    fp_add = y;
        else if (x[30:23] == 8'd0 && y[30:23] == 8'd0)     fp_add = {x[31] & y[31], 31'd0};
        else if (x[30:23] == 8'd0)                         fp_add = y;
        else if (y[30:23] == 8'd0)                         fp_add = x;
        else if (sum == 28'd0)                             fp_add = 32'h00000000;
        else fp_add = fp_pack(l[31], e, sum[26:3], sum[2], |sum[1:0]);
    endfunction

    always_comb begin
        phase_d = phase_q;
        a_op_d  = a_op_q;
        b_op_d  = b_op_q;
        z_d     = z_q;
        z_stb_d = z_stb_q;
        ack_d   = 1'b0;
        case (phase_q)
            F_IDLE: if (a_stb && b_stb) begin
                a_op_d  = a;
                b_op_d  = b;
                ack_d   = 1'b1;
                phase_d = F_CALC;
            end
            F_CALC: begin
                z_d     = IS_ADD ? fp_add(a_op_q, b_op_q) : fp_mul(a_op_q, b_op_q);
                z_stb_d = 1'b1;
                phase_d = F_DONE;
            end
            F_DONE: if (z_ack) begin
                z_stb_d = 1'b0;
                phase_d = F_IDLE;
            end
            default: phase_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= F_IDLE;
            a_op_q  <= 32'd0;
            b_op_q  <= 32'd0;
            z_q     <= 32'd0;
            z_stb_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            a_op_q  <= a_op_d;
            b_op_q  <= b_op_d;
            z_q     <= z_d;
            z_stb_q <= z_stb_d;
            ack_q   <= ack_d;
        end
    end

    assign a_ack = ack_q;
    assign b_ack = ack_q;
    assign z     = z_q;
    assign z_stb = z_stb_q;
endmodule

module specular_term #(
    parameter logic [31:0] CONST_1 = 32'h3f800000,
    parameter logic [31:0] CONST_0 = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ready,
    input  logic        data_valid,
    output logic        calc_done,
    input  logic        read_done,
    input  logic [31:0] n_x,
    input  logic [31:0] n_y,
    input  logic [31:0] n_z,
    input  logic [31:0] h_x,
    input  logic [31:0] h_y,
    input  logic [31:0] h_z,
    input  logic [31:0] shininess,
    output logic [31:0] result,
    input  logic        pow_ready,
    output logic        pow_data_valid,
    output logic [31:0] pow_base,
    output logic [31:0] pow_exp,
    input  logic        pow_calc_done,
    output logic        pow_read_done,
    input  logic [31:0] pow_result
);
    localparam logic [3:0] IDLE = 4'd0, MUL_X = 4'd1, MUL_Y = 4'd2, MUL_Z = 4'd3,
                           ADD_XY = 4'd4, ADD_XYZ = 4'd5, CLAMP = 4'd6, POW_REQ = 4'd7,
                           POW_WAIT = 4'd8, OUTPUT = 4'd9, WAIT_READ = 4'd10;

    logic [3:0]       state_q, state_d;
    logic [6:0][31:0] in_q, in_d;      // n_x, n_y, n_z, h_x, h_y, h_z, shininess
    logic [2:0][31:0] prod_q, prod_d;
    logic [31:0]      s_q, s_d, d_q, d_d, result_q, result_d, base_q, base_d, exp_q, exp_d;
    logic             ready_q, ready_d, calc_done_q, calc_done_d, pdv_q, pdv_d, prd_q, prd_d;
    logic             mul_a_stb_q, mul_a_stb_d, mul_b_stb_q, mul_b_stb_d, mul_z_ack_q, mul_z_ack_d;
    logic             add_a_stb_q, add_a_stb_d, add_b_stb_q, add_b_stb_d, add_z_ack_q, add_z_ack_d;
    logic [31:0]      mul_a, mul_b, mul_z, add_a, add_b, add_z;
    logic             mul_a_ack, mul_b_ack, mul_z_stb, add_a_ack, add_b_ack, add_z_stb;

    // Sign set covers -0; NaN maps to zero; anything above 1.0 (incl. +inf) saturates.
    function automatic logic [31:0] clamp01(input logic [31:0] d);
        if (d[31] || (d[30:23] == 8'hff && d[22:0] != 23'd0)) clamp01 = CONST_0;
        else if (d[30:0] > CONST_1[30:0])                     clamp01 = CONST_1;
        else                                                  clamp01 = d;
    endfunction

    always_comb begin
        mul_a = (state_q == MUL_Y) ? in_q[1] : (state_q == MUL_Z) ? in_q[2] : in_q[0];
        mul_b = (state_q == MUL_Y) ? in_q[4] : (state_q == MUL_Z) ? in_q[5] : in_q[3];
        add_a = (state_q == ADD_XYZ) ? s_q : prod_q[0];
        add_b = (state_q == ADD_XYZ) ? prod_q[2] : prod_q[1];
    end

    always_comb begin
        state_d = state_q;  in_d = in_q;  prod_d = prod_q;  s_d = s_q;  d_d = d_q;
        result_d = result_q;  base_d = base_q;  exp_d = exp_q;
        ready_d = ready_q;  calc_done_d = calc_done_q;  pdv_d = 1'b0;  prd_d = 1'b0;
        mul_a_stb_d = mul_a_stb_q & ~mul_a_ack;
        mul_b_stb_d = mul_b_stb_q & ~mul_b_ack;
        add_a_stb_d = add_a_stb_q & ~add_a_ack;
        add_b_stb_d = add_b_stb_q & ~add_b_ack;
        mul_z_ack_d = 1'b0;
        add_z_ack_d = 1'b0;
        case (state_q)
            IDLE: if (data_valid && ready_q) begin
                in_d        = {shininess, h_z, h_y, h_x, n_z, n_y, n_x};
                ready_d     = 1'b0;
                mul_a_stb_d = 1'b1;
                mul_b_stb_d = 1'b1;
                state_d     = MUL_X;
            end
            MUL_X, MUL_Y, MUL_Z: if (mul_z_stb && !mul_z_ack_q) begin
                mul_z_ack_d                   = 1'b1;
                prod_d[state_q[1:0] - 2'd1]   = mul_z;
                if (state_q == MUL_Z) begin
                    add_a_stb_d = 1'b1;
                    add_b_stb_d = 1'b1;
                end else begin
                    mul_a_stb_d = 1'b1;
                    mul_b_stb_d = 1'b1;
                end
                state_d = state_q + 4'd1;
            end
            ADD_XY, ADD_XYZ: if (add_z_stb && !add_z_ack_q) begin
                add_z_ack_d = 1'b1;
                if (state_q == ADD_XY) begin
                    s_d         = add_z;
                    add_a_stb_d = 1'b1;
                    add_b_stb_d = 1'b1;
                end else begin
                    d_d = add_z;
                end
                state_d = state_q + 4'd1;
            end
            CLAMP: begin
                base_d  = clamp01(d_q);
                exp_d   = in_q[6][31] ? 32'd0 : in_q[6];
                state_d = POW_REQ;
            end
            POW_REQ: if (pow_ready) begin
                pdv_d   = 1'b1;
                state_d = POW_WAIT;
            end
            POW_WAIT: if (pow_calc_done) begin
                result_d = pow_result;
                prd_d    = 1'b1;
                state_d  = OUTPUT;
            end
            OUTPUT: begin
                calc_done_d = 1'b1;
                state_d     = WAIT_READ;
            end
            WAIT_READ: if (read_done) begin
                calc_done_d = 1'b0;
                ready_d     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;  in_q <= '0;  prod_q <= '0;  s_q <= '0;  d_q <= '0;
            result_q <= '0;  base_q <= '0;  exp_q <= '0;
            ready_q <= 1'b1;  calc_done_q <= 1'b0;  pdv_q <= 1'b0;  prd_q <= 1'b0;
            mul_a_stb_q <= 1'b0;  mul_b_stb_q <= 1'b0;  mul_z_ack_q <= 1'b0;
            add_a_stb_q <= 1'b0;  add_b_stb_q <= 1'b0;  add_z_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;  in_q <= in_d;  prod_q <= prod_d;  s_q <= s_d;  d_q <= d_d;
            result_q <= result_d;  base_q <= base_d;  exp_q <= exp_d;
            ready_q <= ready_d;  calc_done_q <= calc_done_d;  pdv_q <= pdv_d;  prd_q <= prd_d;
            mul_a_stb_q <= mul_a_stb_d;  mul_b_stb_q <= mul_b_stb_d;  mul_z_ack_q <= mul_z_ack_d;
            add_a_stb_q <= add_a_stb_d;  add_b_stb_q <= add_b_stb_d;  add_z_ack_q <= add_z_ack_d;
        end
    end

    specular_fpu #(.IS_ADD(1'b0)) u_mul (
        .clk(clk), .rst_n(rst_n), .a(mul_a), .b(mul_b), .a_stb(mul_a_stb_q), .b_stb(mul_b_stb_q),
        .a_ack(mul_a_ack), .b_ack(mul_b_ack), .z(mul_z), .z_stb(mul_z_stb), .z_ack(mul_z_ack_q)
    );

    specular_fpu #(.IS_ADD(1'b1)) u_add (
        .clk(clk), .rst_n(rst_n), .a(add_a), .b(add_b), .a_stb(add_a_stb_q), .b_stb(add_b_stb_q),
        .a_ack(add_a_ack), .b_ack(add_b_ack), .z(add_z), .z_stb(add_z_stb), .z_ack(add_z_ack_q)
    );

    assign ready          = ready_q;
    assign calc_done      = calc_done_q;
    assign result         = result_q;
    assign pow_data_valid = pdv_q;
    assign pow_read_done  = prd_q;
    assign pow_base       = base_q;
    assign pow_exp        = exp_q;
endmodule

// File: tb/tb_specular_term.sv
// Directed bench for specular_term with a behavioural model of the downstream power unit.
module tb_specular_term;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_valid = 1'b0, read_done = 1'b0;
    logic [31:0] n_x = '0, n_y = '0, n_z = '0, h_x = '0, h_y = '0, h_z = '0, shininess = '0;
    logic        ready, calc_done, pow_ready, pow_data_valid, pow_read_done;
    logic        pow_calc_done = 1'b0;
    logic [31:0] result, pow_base, pow_exp;
    logic [31:0] pow_result = '0;

    always #5 clk = ~clk;

    specular_term dut (
        .clk(clk), .rst_n(rst_n), .ready(ready), .data_valid(data_valid), .calc_done(calc_done),
        .read_done(read_done), .n_x(n_x), .n_y(n_y), .n_z(n_z), .h_x(h_x), .h_y(h_y), .h_z(h_z),
        .shininess(shininess), .result(result), .pow_ready(pow_ready),
        .pow_data_valid(pow_data_valid), .pow_base(pow_base), .pow_exp(pow_exp),
        .pow_calc_done(pow_calc_done), .pow_read_done(pow_read_done), .pow_result(pow_result)
    );

    function automatic real f32_to_real(input logic [31:0] f);
        if (f[30:23] == 8'd0) return 0.0;
        return $bitstoreal({f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] bits;
        logic [24:0] m;
        int          e;
        if (r == 0.0) return 32'h0;
        bits = $realtobits(r);
        e    = int'(bits[62:52]) - 896;
        m    = {2'b01, bits[51:29]};
        if (bits[28] && ((|bits[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {bits[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] pow_model(input logic [31:0] base, input logic [31:0] ex);
        real b, r;
        b = f32_to_real(base);
        r = 1.0;
        for (int i = 0; i < int'(ex) && i < 64; i++) r = r * b;
        return real_to_f32(r);
    endfunction

    // Power unit model: samples operands pow_lat cycles after the strobe and flags any drift.
    int          pow_lat = 3;
    int          pulses = 0, hold_errs = 0, cnt = 0;
    logic        busy = 1'b0;
    logic [31:0] cap_base = '0, cap_exp = '0;
    assign pow_ready = ~busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            cnt           <= 0;
            pow_calc_done <= 1'b0;
            pow_result    <= '0;
        end else begin
            if (pow_data_valid) begin
                pulses   <= pulses + 1;
                busy     <= 1'b1;
                cnt      <= 0;
                cap_base <= pow_base;
                cap_exp  <= pow_exp;
            end else if (busy && !pow_calc_done) begin
                if (cnt == pow_lat) begin
                    if (pow_base !== cap_base || pow_exp !== cap_exp) hold_errs <= hold_errs + 1;
                    pow_result    <= pow_model(pow_base, pow_exp);
                    pow_calc_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1;
                end
            end
            if (pow_calc_done && pow_read_done) begin
                pow_calc_done <= 1'b0;
                busy          <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [31:0] nx, ny, nz, hx, hy, hz, shin, base, pexp, res;
        int          tol;
    } vec_t;

    localparam logic [31:0] ZR = 32'h00000000, ONE = 32'h3f800000, M1 = 32'hbf800000;
    localparam logic [31:0] P6 = 32'h3f19999a, P8 = 32'h3f4ccccd, HALF = 32'h3f000000;
    localparam logic [31:0] MHALF = 32'hbf000000, TWO = 32'h40000000, QTR = 32'h3e800000;
    localparam logic [31:0] MQTR = 32'hbe800000, P75 = 32'h3f400000, EIGHTH = 32'h3e000000;
    localparam logic [31:0] INF = 32'h7f800000;
    localparam int NV = 14;

    vec_t vecs[NV];
    int   tests = 0, fails = 0, p0 = 0, h0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic chk_ulp(input string name, input logic [31:0] act, input logic [31:0] exp_v,
                           input int tol);
        logic [31:0] diff;
        tests++;
        diff = (act > exp_v) ? act - exp_v : exp_v - act;
        if ((^act === 1'bx) || diff > 32'(tol)) begin
            fails++;
            $display("FAIL %s: got %h expected %h (+/-%0d ulp)", name, act, exp_v, tol);
        end
    endtask

    task automatic send(input vec_t v);
        for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
        chk("ready_before_send", 32'(ready), 32'd1);
        p0 = pulses;
        h0 = hold_errs;
        {n_x, n_y, n_z, h_x, h_y, h_z, shininess} = {v.nx, v.ny, v.nz, v.hx, v.hy, v.hz, v.shin};
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        {n_x, n_y, n_z, h_x, h_y, h_z, shininess} = {7{32'hdeadbeef}};
        chk("ready_low_after_accept", 32'(ready), 32'd0);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (calc_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL calc_done_timeout: got 0 expected 1 within 400 cycles");
        end
    endtask

    task automatic check_txn(input vec_t v, input int idx);
        $display("[TB] txn %0d base=%h exp=%h result=%h", idx, cap_base, cap_exp, result);
        chk_ulp("result", result, v.res, v.tol);
        chk("pow_base", cap_base, v.base);
        chk("pow_exp", cap_exp, v.pexp);
        chk("pow_pulses", 32'(pulses - p0), 32'd1);
        chk("pow_operand_hold", 32'(hold_errs - h0), 32'd0);
    endtask

    task automatic release_result();
        read_done = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
        chk("calc_done_after_read", 32'(calc_done), 32'd0);
        chk("ready_after_read", 32'(ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        send(v);
        wait_done(ok);
        if (ok) check_txn(v, idx);
        release_result();
    endtask

    initial begin
        bit ok;
        vecs[0]  = '{ZR, ZR, ONE, ZR, ZR, ONE, 32'd8, ONE, 32'd8, ONE, 0};
        vecs[1]  = '{ZR, ZR, ONE, ZR, P6, P8, 32'd2, P8, 32'd2, 32'h3f23d70a, 1};
        vecs[2]  = '{ZR, ZR, ONE, ZR, ZR, M1, 32'd4, ZR, 32'd4, ZR, 0};
        vecs[3]  = '{ZR, ZR, ONE, ZR, ZR, ONE, 32'hfffffffc, ONE, 32'd0, ONE, 0};
        vecs[4]  = '{ZR, ZR, ONE, ZR, P6, P8, 32'd0, P8, 32'd0, ONE, 0};
        vecs[5]  = '{HALF, HALF, HALF, HALF, HALF, HALF, 32'd2, P75, 32'd2, 32'h3f100000, 0};
        vecs[6]  = '{TWO, ONE, HALF, QTR, MHALF, HALF, 32'd3, QTR, 32'd3, 32'h3c800000, 0};
        vecs[7]  = '{ONE, ONE, ZR, ONE, ONE, ZR, 32'd5, ONE, 32'd5, ONE, 0};
        vecs[8]  = '{INF, ZR, ZR, ONE, ZR, ZR, 32'd1, ONE, 32'd1, ONE, 0};
        vecs[9]  = '{INF, ZR, ZR, ZR, ZR, ZR, 32'd1, ZR, 32'd1, ZR, 0};
        vecs[10] = '{M1, M1, M1, ZR, ZR, ZR, 32'd2, ZR, 32'd2, ZR, 0};
        vecs[11] = '{ZR, ZR, ONE, ZR, ZR, 32'h3f7fffff, 32'd1, 32'h3f7fffff, 32'd1, 32'h3f7fffff, 0};
        vecs[12] = '{ZR, ZR, ONE, ZR, ZR, 32'h3f800001, 32'd3, ONE, 32'd3, ONE, 0};
        vecs[13] = '{ONE, ONE, ONE, P75, MQTR, EIGHTH, 32'd1, 32'h3f200000, 32'd1, 32'h3f200000, 0};

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_calc_done", 32'(calc_done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_pow_data_valid", 32'(pow_data_valid), 32'd0);
        chk("rst_pow_read_done", 32'(pow_read_done), 32'd0);
        chk("rst_pow_base", pow_base, 32'd0);
        chk("rst_pow_exp", pow_exp, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NV; k++) run_vec(vecs[k], k);

        // Consumer stalls for 10 cycles; a request arriving meanwhile must be dropped.
        send(vecs[5]);
        wait_done(ok);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                {n_x, n_y, n_z, h_x, h_y, h_z, shininess} =
                    {vecs[0].nx, vecs[0].ny, vecs[0].nz, vecs[0].hx, vecs[0].hy, vecs[0].hz, vecs[0].shin};
                data_valid = 1'b1;
            end
            if (i == 4) data_valid = 1'b0;
            @(negedge clk);
            chk("stall_calc_done", 32'(calc_done), 32'd1);
            chk("stall_result", result, vecs[5].res);
            chk("stall_ready", 32'(ready), 32'd0);
        end
        release_result();
        repeat (30) @(negedge clk);
        chk("stall_request_dropped", 32'(pulses - p0), 32'd1);
        chk("stall_idle_calc_done", 32'(calc_done), 32'd0);

        // Asynchronous reset while the power unit is still busy.
        pow_lat = 20;
        send(vecs[0]);
        for (int i = 0; i < 200 && pulses == p0; i++) @(negedge clk);
        chk("reached_pow_wait", 32'(pulses - p0), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_calc_done", 32'(calc_done), 32'd0);
        chk("midrst_pow_data_valid", 32'(pow_data_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_pow_base", pow_base, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pow_lat = 3;
        @(negedge clk);
        run_vec(vecs[6], 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2000000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
